// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller for a dual-address FIFO storage array.
// Optional almost-full/almost-empty flags are built only when FIFO_ALMOST_FLAGS_EN is defined.
module fifo_ctrl #(
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    output logic                  write_enable,
    output logic                  read_enable,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output logic                  data_valid
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  valid_q, valid_d;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Enables are gated by reset so the array never sees a write while reset is held.
    assign write_enable = reset_L & push & (~full | pop);
    assign read_enable  = reset_L & pop & ~empty;

    assign write_addr    = wr_ptr_q;
    assign read_addr     = rd_ptr_q;
    assign fifo_count    = count_q;
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;
    assign data_valid    = valid_q;

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [ADDR_WIDTH:0] AF_TH_C = ALMOST_FULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_TH_C = ALMOST_EMPTY_TH[ADDR_WIDTH:0];

    assign almost_full  = (count_q >= AF_TH_C);
    assign almost_empty = (count_q <= AE_TH_C);
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (write_enable) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (read_enable) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous accepted write and read leave occupancy unchanged.
        if (write_enable && !read_enable) begin
            count_d = count_q + 1'b1;
        end else if (read_enable && !write_enable) begin
            count_d = count_q - 1'b1;
        end
        overflow_d  = push & full & ~pop;
        underflow_d = pop & empty;
        valid_d     = read_enable;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            valid_q     <= valid_d;
        end
    end

endmodule
